rx30_align: RTL and testbench
=============================

# rx30_align

Receive-side word aligner for the 30-lane, 10:1 LVDS link. It sits between the 30-channel LVDS deserializer (`lvds_rx30`) and the receive core. It drives per-lane bitslip pulses until every lane presents the training word, then registers and forwards the aligned 300-bit parallel bus. It is the far-end counterpart of the transmit serializer path.

## Interface
- TRAIN_PATTERN, 10'h3E0, training word. All 10 rotations must be distinct.
- MATCH_COUNT, 8, consecutive matching words required to lock a lane (≥1).
- SLIP_WAIT, 4, cycles to wait after a bitslip pulse before comparing again (≥1). Covers deserializer slip latency.

Ports:
- I_clk  in  1  core clock (deserializer coreclock domain)
- I_rst_n  in  1  reset, synchronous, active-low
- I_pll_locked  in  1  deserializer PLL lock
- I_train_start  in  1  single-cycle pulse; (re)starts alignment of all lanes
- I_rx_in  in  300  deserializer words; lane k = bits [10k+9:10k]
- O_rx_bitslip  out  30  per-lane bitslip pulse to deserializer
- O_lane_locked  out  30  lane k aligned
- O_lane_fail  out  30  lane k exhausted all rotations without lock
- O_busy  out  1  any lane in CHECK/SLIP/WAIT
- O_aligned  out  1  all 30 lanes locked
- O_rx_data  out  300  I_rx_in registered once
- O_rx_valid  out  1  O_aligned, aligned in time with O_rx_data

## Operation
- One independent FSM per lane with states IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL. Per lane: match_cnt (0..MATCH_COUNT-1), slip_cnt (0..9), wait_cnt (0..SLIP_WAIT-1).
- IDLE: bitslip 0. I_train_start=1 and I_pll_locked=1 → CHECK; clear all counters, locked, and fail.
- CHECK: lane word == TRAIN_PATTERN → match_cnt++. On the MATCH_COUNT-th consecutive match → LOCKED.
  - On a mismatch: match_cnt←0.
  - If slip_cnt==9 → FAIL.
  - Otherwise → SLIP and slip_cnt++.
- SLIP: O_rx_bitslip[k]=1 for exactly this cycle → WAIT with wait_cnt←0.
- WAIT: wait_cnt counts to SLIP_WAIT-1 → CHECK. Words arriving during WAIT are ignored.
- LOCKED: O_lane_locked[k]=1. Holds until retrain, PLL loss, or reset. Data is not monitored after lock.
- FAIL: O_lane_fail[k]=1. Holds until retrain, PLL loss, or reset.
- Global rules, highest priority first:
  - reset;
  - I_pll_locked=0 → all lanes IDLE, locked and fail cleared;
  - I_train_start=1 → all lanes CHECK with counters cleared. This applies in any state, including mid-training.
- I_train_start while I_pll_locked=0 is ignored.
- O_aligned = registered AND of O_lane_locked. O_busy = registered OR of lanes in CHECK/SLIP/WAIT.
- O_rx_data ← I_rx_in every cycle, unconditionally. O_rx_valid ← O_aligned, so valid marks data sampled after full alignment.

## Timing
- Reset value of every output is 0. All outputs are registered.
- Start pulse sampled at edge t → lane in CHECK during cycle t+1.
- Each slip costs SLIP_WAIT+2 cycles: the mismatch cycle, the SLIP cycle, and SLIP_WAIT cycles of WAIT.
- A lane needing n slips (0..9) shows O_lane_locked at cycle t+1+n·(SLIP_WAIT+2)+MATCH_COUNT. With defaults this is t+9+6n.
- O_aligned rises one cycle after the last lane lock. O_rx_valid rises one cycle after O_aligned.
- FAIL is asserted at cycle t+1+9·(SLIP_WAIT+2)+1+j, where j is the number of matches before the final mismatch.
- A bitslip pulse is never wider than 1 cycle. Consecutive pulses on a lane are ≥SLIP_WAIT+2 cycles apart.
- I_pll_locked falling: all per-lane outputs, O_aligned, and O_busy are 0 one cycle later. O_rx_valid follows one cycle after that.

## Test plan
- Reset with I_rst_n=0 for 3 cycles and random I_rx_in → all outputs 0; no bitslip pulses.
- All lanes already aligned (pattern 0x3E0), pulse start at t → no bitslip; O_lane_locked=all-ones at t+9; O_aligned at t+10; O_rx_valid at t+11.
- Bench rotator model: lane k starts rotated by k mod 10 and each slip rotates it by 1 → lane k gets exactly k mod 10 pulses 6 cycles apart; O_aligned at t+64 (t+63 lock for n=9 plus one cycle).
- Lane 7 driven constant 10'h000 → lane 7 gets 9 pulses then O_lane_fail[7]=1; O_aligned stays 0; other lanes lock.
- Drop I_pll_locked during WAIT, then restore and pulse start → next cycle all IDLE and bitslip 0; after restart, counters are fresh and lock timing matches scenario 2 or 3.
- Second start pulse mid-training (after 3 slips on lane 5) → slip_cnt cleared; lane 5 needs only its remaining rotations; no FAIL asserted.

Source files
------------

// File: rtl/rx30_align.sv
// Receive-side word aligner for the 30-lane 10:1 LVDS link: per-lane bitslip
// training against a fixed word, then a registered 300-bit forward path.
module rx30_align #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'h3E0,
  parameter int unsigned MATCH_COUNT   = 8,
  parameter int unsigned SLIP_WAIT     = 4
) (
  input  logic         I_clk,
  input  logic         I_rst_n,
  input  logic         I_pll_locked,
  input  logic         I_train_start,
  input  logic [299:0] I_rx_in,
  output logic [29:0]  O_rx_bitslip,
  output logic [29:0]  O_lane_locked,
  output logic [29:0]  O_lane_fail,
  output logic         O_busy,
  output logic         O_aligned,
  output logic [299:0] O_rx_data,
  output logic         O_rx_valid
);

  localparam int unsigned LANES = 30;
  localparam int unsigned MW    = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
  localparam int unsigned WW    = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
  localparam logic [3:0]    SLIP_LAST  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } lane_state_t;

  logic [LANES-1:0] lane_active_d;
  logic             aligned_q;
  logic             busy_q;
  logic             valid_q;
  logic [299:0]     data_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_state_t   state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [3:0]    slip_q, slip_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          locked_q, fail_q, pulse_q;
    logic [9:0]    word;

    assign word = I_rx_in[10*k +: 10];

    always_comb begin
      state_d = state_q;
      match_d = match_q;
      slip_d  = slip_q;
      wait_d  = wait_q;
      if (!I_pll_locked) begin
        state_d = ST_IDLE;
        match_d = '0;
        slip_d  = '0;
        wait_d  = '0;
      end else if (I_train_start) begin
        state_d = ST_CHECK;
        match_d = '0;
        slip_d  = '0;
        wait_d  = '0;
      end else begin
        case (state_q)
          ST_CHECK: begin
            if (word == TRAIN_PATTERN) begin
              if (match_q == MATCH_LAST) state_d = ST_LOCKED;
              else                       match_d = match_q + 1'b1;
            end else begin
              match_d = '0;
              if (slip_q == SLIP_LAST) begin
                state_d = ST_FAIL;
              end else begin
                state_d = ST_SLIP;
                slip_d  = slip_q + 1'b1;
              end
            end
          end
          ST_SLIP: begin
            state_d = ST_WAIT;
            wait_d  = '0;
          end
          ST_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = ST_CHECK;
            else                     wait_d  = wait_q + 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Lane outputs are decoded from the next state so they appear as flops
    // in the same cycle the lane occupies the corresponding state.
    always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
        state_q  <= ST_IDLE;
        match_q  <= '0;
        slip_q   <= '0;
        wait_q   <= '0;
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        match_q  <= match_d;
        slip_q   <= slip_d;
        wait_q   <= wait_d;
        locked_q <= (state_d == ST_LOCKED);
        fail_q   <= (state_d == ST_FAIL);
        pulse_q  <= (state_d == ST_SLIP);
      end
    end

    assign lane_active_d[k] = (state_d == ST_CHECK) || (state_d == ST_SLIP) ||
                              (state_d == ST_WAIT);
    assign O_lane_locked[k] = locked_q;
    assign O_lane_fail[k]   = fail_q;
    assign O_rx_bitslip[k]  = pulse_q;
  end

  // Aligned drops together with the lane flags on PLL loss or retrain.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      aligned_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      aligned_q <= I_pll_locked & ~I_train_start & (&O_lane_locked);
      busy_q    <= |lane_active_d;
      valid_q   <= aligned_q;
      data_q    <= I_rx_in;
    end
  end

  assign O_aligned  = aligned_q;
  assign O_busy     = busy_q;
  assign O_rx_valid = valid_q;
  assign O_rx_data  = data_q;

endmodule

// File: tb/tb_rx30_align.sv
// Directed/randomized bench for rx30_align with a rotating-deserializer model
// and closed-form expected lock, slip and fail timing.
module tb_rx30_align;

  localparam logic [9:0] PAT    = 10'h3E0;
  localparam int         MC     = 8;
  localparam int         SW     = 4;
  localparam int         SLOT   = SW + 2;
  localparam int         FAIL_C = 1 + 9 * SLOT + 1;

  logic         I_clk = 1'b0;
  logic         I_rst_n;
  logic         I_pll_locked;
  logic         I_train_start;
  logic [299:0] I_rx_in;
  logic [29:0]  O_rx_bitslip;
  logic [29:0]  O_lane_locked;
  logic [29:0]  O_lane_fail;
  logic         O_busy;
  logic         O_aligned;
  logic [299:0] O_rx_data;
  logic         O_rx_valid;

  int checks = 0;
  int errors = 0;
  int off[30];
  bit cst[30];
  int need[30];
  bit fl_lane[30];
  int pulses[30];
  int cyc;
  logic [299:0] last_rx;

  rx30_align #(
    .TRAIN_PATTERN(PAT),
    .MATCH_COUNT  (MC),
    .SLIP_WAIT    (SW)
  ) dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_pll_locked (I_pll_locked),
    .I_train_start(I_train_start),
    .I_rx_in      (I_rx_in),
    .O_rx_bitslip (O_rx_bitslip),
    .O_lane_locked(O_lane_locked),
    .O_lane_fail  (O_lane_fail),
    .O_busy       (O_busy),
    .O_aligned    (O_aligned),
    .O_rx_data    (O_rx_data),
    .O_rx_valid   (O_rx_valid)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] d;
    d = {w, w};
    return d[19-r -: 10];
  endfunction

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    last_rx = I_rx_in;
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive_rx();
    for (int k = 0; k < 30; k++)
      I_rx_in[10*k +: 10] = cst[k] ? 10'h000 : rotl(PAT, off[k]);
  endtask

  // Deserializer model: each observed pulse rotates the lane back by one bit.
  task automatic apply_slips();
    for (int k = 0; k < 30; k++) begin
      if (O_rx_bitslip[k]) begin
        pulses[k]++;
        if (!cst[k]) off[k] = (off[k] + 9) % 10;
      end
    end
  endtask

  task automatic check_zero(input logic [299:0] exp_data);
    chk("bitslip_zero", 300'(O_rx_bitslip), '0);
    chk("locked_zero",  300'(O_lane_locked), '0);
    chk("fail_zero",    300'(O_lane_fail), '0);
    chk("aligned_zero", 300'(O_aligned), '0);
    chk("busy_zero",    300'(O_busy), '0);
    chk("valid_zero",   300'(O_rx_valid), '0);
    chk("rx_data",      O_rx_data, exp_data);
  endtask

  task automatic check_cycle();
    logic [29:0] ebs, elk, efl;
    logic eal, eva, ebz;
    int n, lock_c, end_c, max_lock;
    bit any_fail;
    ebs = '0; elk = '0; efl = '0; ebz = 1'b0;
    max_lock = 0; any_fail = 1'b0;
    for (int k = 0; k < 30; k++) begin
      n      = fl_lane[k] ? 9 : need[k];
      lock_c = 1 + n * SLOT + MC;
      end_c  = fl_lane[k] ? FAIL_C : lock_c;
      ebs[k] = (cyc >= 2) && ((cyc - 2) % SLOT == 0) && ((cyc - 2) / SLOT < n);
      elk[k] = !fl_lane[k] && (cyc >= lock_c);
      efl[k] = fl_lane[k] && (cyc >= FAIL_C);
      if (cyc < end_c) ebz = 1'b1;
      if (fl_lane[k]) any_fail = 1'b1;
      else if (lock_c > max_lock) max_lock = lock_c;
    end
    eal = !any_fail && (cyc >= max_lock + 1);
    eva = !any_fail && (cyc >= max_lock + 2);
    chk("bitslip", 300'(O_rx_bitslip), 300'(ebs));
    chk("locked",  300'(O_lane_locked), 300'(elk));
    chk("fail",    300'(O_lane_fail), 300'(efl));
    chk("aligned", 300'(O_aligned), 300'(eal));
    chk("valid",   300'(O_rx_valid), 300'(eva));
    chk("busy",    300'(O_busy), 300'(ebz));
    chk("rx_data", O_rx_data, last_rx);
  endtask

  task automatic begin_train();
    for (int k = 0; k < 30; k++) begin
      need[k]    = off[k];
      fl_lane[k] = cst[k];
    end
    drive_rx();
    I_train_start = 1'b1;
    step();
    I_train_start = 1'b0;
    cyc = 1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      check_cycle();
      apply_slips();
      drive_rx();
      step();
      cyc++;
    end
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    cyc = 0;
    repeat (3) begin
      for (int i = 0; i < 10; i++) I_rx_in[30*i +: 30] = 30'($urandom);
      I_train_start = 1'($urandom);
      step();
      check_zero('0);
    end
    I_rst_n = 1'b1;
    I_train_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      pulses[k] = 0;
      cst[k]    = 1'b0;
    end
    step();
    check_zero(last_rx);
  endtask

  initial begin
    int drop_c;
    I_rst_n = 1'b0;
    I_pll_locked = 1'b1;
    I_train_start = 1'b0;
    I_rx_in = '0;
    cyc = 0;

    // Reset with random data, then lanes already aligned.
    do_reset();
    for (int k = 0; k < 30; k++) off[k] = 0;
    begin_train();
    run(14);
    check_cycle();
    I_pll_locked = 1'b0;
    step();
    cyc++;
    chk("pll_drop_locked",  300'(O_lane_locked), '0);
    chk("pll_drop_aligned", 300'(O_aligned), '0);
    chk("pll_drop_busy",    300'(O_busy), '0);
    chk("pll_drop_valid_lag", 300'(O_rx_valid), 300'(1'b1));
    step();
    cyc++;
    check_zero(last_rx);
    I_pll_locked = 1'b1;

    // Lane k starts rotated by k mod 10.
    do_reset();
    for (int k = 0; k < 30; k++) off[k] = k % 10;
    begin_train();
    run(70);
    for (int k = 0; k < 30; k++) chk("pulse_count", 300'(pulses[k]), 300'(k % 10));

    // Lane 7 stuck at zero exhausts every rotation.
    do_reset();
    for (int k = 0; k < 30; k++) off[k] = k % 10;
    cst[7] = 1'b1;
    begin_train();
    run(66);
    chk("lane7_pulses", 300'(pulses[7]), 300'(9));
    cst[7] = 1'b0;

    // Random rotations, PLL lost during WAIT, start ignored while unlocked.
    do_reset();
    for (int k = 0; k < 30; k++) off[k] = int'($urandom_range(9, 0));
    drop_c = int'($urandom_range(6, 3));
    begin_train();
    run(drop_c - 1);
    check_cycle();
    apply_slips();
    drive_rx();
    I_pll_locked = 1'b0;
    step();
    cyc++;
    check_zero(last_rx);
    I_train_start = 1'b1;
    step();
    I_train_start = 1'b0;
    cyc++;
    check_zero(last_rx);
    step();
    cyc++;
    check_zero(last_rx);
    I_pll_locked = 1'b1;
    step();
    cyc++;
    check_zero(last_rx);
    begin_train();
    run(70);

    // Retrain after lane 5 has taken three slips.
    do_reset();
    for (int k = 0; k < 30; k++) off[k] = k % 10;
    begin_train();
    run(15);
    chk("lane5_pulses_mid", 300'(pulses[5]), 300'(3));
    begin_train();
    run(70);
    chk("lane5_pulses_total", 300'(pulses[5]), 300'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
